// File: rtl/spi_word_rx_if.sv
// SPI pin bundle plus the received-word outputs of spi_word_rx.
interface spi_word_rx_if #(
    parameter int BITS = 32
);
    logic            SS;
    logic            SCLK;
    logic            MOSI;
    logic [BITS-1:0] data_out;
    logic            valid;
    logic            busy;
    logic            err;

    modport master (
        output SS, SCLK, MOSI,
        input  data_out, valid, busy, err
    );

    modport slave (
        input  SS, SCLK, MOSI,
        output data_out, valid, busy, err
    );
endinterface

// File: rtl/spi_word_rx.sv
// SPI slave receiver: one BITS-wide MSB-first word per SS-low frame, oversampled by clk.
// Latency: valid/err rise SYNC_STAGES+1 clk edges after SS goes high; no backpressure, data_out holds until the next valid.
// SPI_RX_FRAME_CHECK_EN adds err pulses for wrong-length frames and for SS falls seen while arming.
module spi_word_rx #(
    parameter int BITS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    spi_word_rx_if.slave bus
);
    localparam int PW    = SYNC_STAGES + 1;
    localparam int CNT_W = $clog2(BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        RECV
    } state_t;

    logic [PW-1:0]          ss_pipe_q, ss_pipe_d;
    logic [PW-1:0]          sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;
    logic [PW-1:0]          fill_q, fill_d;
    state_t                 state_q, state_d;
    logic [BITS-1:0]        shift_q, shift_d;
    logic [BITS-1:0]        data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;

    logic ss_sync, ss_rise, ss_fall, sclk_rise, mosi_sync;

    assign ss_sync   = ss_pipe_q[SYNC_STAGES-1];
    assign ss_rise   = ss_sync & ~ss_pipe_q[SYNC_STAGES];
    assign ss_fall   = ~ss_sync & ss_pipe_q[SYNC_STAGES];
    assign sclk_rise = sclk_pipe_q[SYNC_STAGES-1] & ~sclk_pipe_q[SYNC_STAGES];
    assign mosi_sync = mosi_pipe_q[SYNC_STAGES-1];

    always_comb begin
        ss_pipe_d   = {ss_pipe_q[PW-2:0], bus.SS};
        sclk_pipe_d = {sclk_pipe_q[PW-2:0], bus.SCLK};
        mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-2:0], bus.MOSI};
        // fill_q marks when the SS pipe and its history hold real samples rather than reset values
        fill_d      = {fill_q[PW-2:0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (state_q)
            ARM: begin
                if (ss_sync && fill_q[PW-1]) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d = RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                // SS release wins over a simultaneous SCLK rise, so that rise is never shifted
                if (ss_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d = {shift_q[BITS-2:0], mosi_sync};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_pipe_q   <= '1;
            sclk_pipe_q <= '0;
            mosi_pipe_q <= '0;
            fill_q      <= '0;
            state_q     <= ARM;
            shift_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            ss_pipe_q   <= ss_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q == RECV);

`ifdef SPI_RX_FRAME_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = 1'b0;
        if ((state_q == ARM) && ss_fall) begin
            err_d = 1'b1;
        end
        if ((state_q == RECV) && ss_rise && (cnt_q != CNT_FULL) && (cnt_q != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_word_rx.sv
// Randomized bench for spi_word_rx: frames are compared against a word-level model of the protocol.
module tb_spi_word_rx;
    localparam int BITS        = 32;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_PH      = SYNC_STAGES + 2;
`ifdef SPI_RX_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_word_rx_if #(.BITS(BITS)) bus ();

    spi_word_rx #(.BITS(BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int err_seen = 0;
    logic [BITS-1:0] last_data = '0;

    int exp_valid = 0;
    int exp_err = 0;
    logic [BITS-1:0] exp_data = '0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            valid_seen++;
            last_data = bus.data_out;
        end
        if (bus.err === 1'b1) err_seen++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Only the frame's SCLK rise count and its bits matter at word level.
    function automatic void model_frame(input logic [63:0] word, input int rises);
        if (rises == BITS) begin
            exp_data = word[BITS-1:0];
            exp_valid++;
        end else if (FRAME_CHECK && rises != 0) begin
            exp_err++;
        end
    endfunction

    // mode 0: SS rises a low phase after the last bit; 1: SS rises 1 cycle after last SCLK rise;
    // 2: an extra SCLK rise coincides with SS rising
    task automatic send_frame(input logic [63:0] word, input int nbits, input int hi,
                              input int lo, input int mode, output logic busy_mid);
        bus.SS   = 1'b0;
        bus.SCLK = 1'b0;
        wait_cycles(lo);
        busy_mid = bus.busy;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.SCLK = 1'b0;
            bus.MOSI = word[i];
            wait_cycles(lo);
            bus.SCLK = 1'b1;
            if (mode == 1 && i == 0) begin
                wait_cycles(1);
                bus.SS = 1'b1;
                wait_cycles(hi - 1);
            end else begin
                wait_cycles(hi);
            end
        end
        bus.SCLK = 1'b0;
        if (mode != 1) begin
            wait_cycles(lo);
            if (mode == 2) begin
                bus.MOSI = ~bus.MOSI;
                bus.SCLK = 1'b1;
            end
            bus.SS = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        wait_cycles(3);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.data_out); end
        reset = 1'b0;
        wait_cycles(8);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_word();
        logic bm;
        int lat, width;
        send_frame(64'h0000_3039, BITS, 5, 5, 0, bm);
        model_frame(64'h0000_3039, BITS);
        checks++; if (bm !== 1'b1) begin errors++; $display("FAIL single_busy_mid got %b want 1", bm); end
        lat = 0; width = 0;
        for (int i = 1; i <= 8; i++) begin
            wait_cycles(1);
            if (bus.valid === 1'b1) begin
                width++;
                if (lat == 0) lat = i;
            end
        end
        checks++; if (lat != SYNC_STAGES + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, SYNC_STAGES + 1); end
        checks++; if (width != 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", width); end
        checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL single_data got %h want %h", bus.data_out, exp_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic bm;
        logic [63:0] words [2];
        words[0] = 64'hFFFF_FFFF;
        words[1] = 64'h8000_0001;
        for (int k = 0; k < 2; k++) begin
            send_frame(words[k], BITS, MIN_PH, MIN_PH, 0, bm);
            model_frame(words[k], BITS);
            wait_cycles(MIN_PH);
            checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, bus.data_out, exp_data); end
            checks++; if (last_data !== exp_data) begin errors++; $display("FAIL b2b_valid_data[%0d] got %h want %h", k, last_data, exp_data); end
            checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL b2b_valid_count[%0d] got %0d want %0d", k, valid_seen, exp_valid); end
        end
    endtask

    task automatic test_bad_length();
        logic bm;
        int lens [2];
        logic [63:0] w;
        lens[0] = BITS - 1;
        lens[1] = BITS + 1;
        for (int k = 0; k < 2; k++) begin
            w = {$urandom, $urandom};
            send_frame(w, lens[k], 5, 4, 0, bm);
            model_frame(w, lens[k]);
            wait_cycles(8);
            checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL badlen_valid[%0d] got %0d want %0d", lens[k], valid_seen, exp_valid); end
            checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL badlen_data[%0d] got %h want %h", lens[k], bus.data_out, exp_data); end
            checks++; if (err_seen != exp_err) begin errors++; $display("FAIL badlen_err[%0d] got %0d want %0d", lens[k], err_seen, exp_err); end
        end
    endtask

    task automatic test_reset_midframe();
        logic bm;
        bus.SS = 1'b0;
        bus.SCLK = 1'b0;
        wait_cycles(MIN_PH);
        for (int i = 0; i < 10; i++) begin
            bus.SCLK = 1'b0; bus.MOSI = 1'($urandom); wait_cycles(MIN_PH);
            bus.SCLK = 1'b1; wait_cycles(MIN_PH);
        end
        bus.SCLK = 1'b0;
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        exp_data = '0;
        if (FRAME_CHECK) exp_err++;
        for (int i = 0; i < 22; i++) begin
            bus.SCLK = 1'b0; bus.MOSI = 1'($urandom); wait_cycles(MIN_PH);
            bus.SCLK = 1'b1; wait_cycles(MIN_PH);
        end
        bus.SCLK = 1'b0;
        wait_cycles(MIN_PH);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        bus.SS = 1'b1;
        wait_cycles(8);
        checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL rstmid_valid got %0d want %0d", valid_seen, exp_valid); end
        checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rstmid_data got %h want %h", bus.data_out, exp_data); end
        checks++; if (err_seen != exp_err) begin errors++; $display("FAIL rstmid_err got %0d want %0d", err_seen, exp_err); end
        send_frame(64'h1234_5678, BITS, 5, 5, 0, bm);
        model_frame(64'h1234_5678, BITS);
        wait_cycles(8);
        checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rstmid_next_data got %h want %h", bus.data_out, exp_data); end
        checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL rstmid_next_valid got %0d want %0d", valid_seen, exp_valid); end
    endtask

    task automatic test_sclk_while_idle();
        logic bm;
        for (int i = 0; i < 40; i++) begin
            bus.SCLK = 1'b1; bus.MOSI = 1'($urandom); wait_cycles(MIN_PH);
            bus.SCLK = 1'b0; wait_cycles(MIN_PH);
        end
        checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL idle_sclk_valid got %0d want %0d", valid_seen, exp_valid); end
        send_frame(64'hA5A5_A5A5, BITS, 4, 6, 0, bm);
        model_frame(64'hA5A5_A5A5, BITS);
        wait_cycles(8);
        checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL idle_sclk_data got %h want %h", bus.data_out, exp_data); end
        checks++; if (err_seen != exp_err) begin errors++; $display("FAIL idle_sclk_err got %0d want %0d", err_seen, exp_err); end
    endtask

    task automatic test_release_timing();
        logic bm;
        logic [63:0] w;
        for (int mode = 1; mode <= 2; mode++) begin
            w = {32'h0, $urandom};
            send_frame(w, BITS, 5, 5, mode, bm);
            model_frame(w, BITS);
            wait_cycles(8);
            checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL release_data[mode%0d] got %h want %h", mode, bus.data_out, exp_data); end
            checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL release_valid[mode%0d] got %0d want %0d", mode, valid_seen, exp_valid); end
            checks++; if (err_seen != exp_err) begin errors++; $display("FAIL release_err[mode%0d] got %0d want %0d", mode, err_seen, exp_err); end
        end
    endtask

    task automatic test_random_frames();
        logic bm;
        logic [63:0] w;
        int sel, nbits, mode;
        for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(0, 9);
            nbits = (sel <= 6) ? BITS : (sel == 7) ? BITS - 1 : (sel == 8) ? BITS + 1 : 0;
            mode = (nbits == 0) ? 0 : $urandom_range(0, 2);
            w = {$urandom, $urandom};
            send_frame(w, nbits, $urandom_range(MIN_PH, 7), $urandom_range(MIN_PH, 7), mode, bm);
            model_frame(w, nbits);
            wait_cycles($urandom_range(MIN_PH + 4, 10));
            checks++; if (bm !== 1'b1) begin errors++; $display("FAIL rand_busy[%0d] got %b want 1", k, bm); end
            checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", k, bus.data_out, exp_data); end
            checks++; if (valid_seen != exp_valid) begin errors++; $display("FAIL rand_valid[%0d] got %0d want %0d", k, valid_seen, exp_valid); end
            checks++; if (err_seen != exp_err) begin errors++; $display("FAIL rand_err[%0d] got %0d want %0d", k, err_seen, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_length();
        test_reset_midframe();
        test_sclk_while_idle();
        test_release_timing();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_word_rx.md
SPI_WORD_RX -- requirements
Module: spi_word_rx

Interface
REQ-001 The block SHALL have parameter BITS, default 32, giving the word length in bits per SPI frame.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops per pin (legal: 2..3).
REQ-003 Port clk  input  1  is the single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port SS  input  1  is SPI slave-select, active low, asynchronous to clk.
REQ-006 Port SCLK  input  1  is the SPI bit clock, asynchronous to clk.
REQ-007 Port MOSI  input  1  is SPI serial data, asynchronous to clk.
REQ-008 Port data_out  output  BITS  is the last complete received word.
REQ-009 Port valid  output  1  is a one-clk pulse marking a new data_out.
REQ-010 Port busy  output  1  is high while a frame is being received (state RECV).
REQ-011 Port err  output  1  is a one-clk pulse marking a malformed frame.

Function
REQ-012 SS, SCLK and MOSI SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection; all logic SHALL use only the synchronized copies.
REQ-013 Protocol: SS low frames a word; MOSI SHALL be sampled on each synchronized SCLK rising edge; the word is sent MSB first.
REQ-014 FSM states SHALL be ARM (wait for SS high), IDLE and RECV.
REQ-015 ARM->IDLE SHALL occur when synchronized SS is high; SCLK activity in ARM is ignored.
REQ-016 IDLE->RECV SHALL occur on the synchronized SS falling edge; this transition clears the shift register and the bit counter.
REQ-017 In RECV, each SCLK rise SHALL shift MOSI into the LSB (shift left); the counter increments and saturates at BITS+1.
REQ-018 RECV->IDLE SHALL occur on the synchronized SS rising edge.
REQ-019 On that edge, if count==BITS, the block SHALL load data_out from the shift register and pulse valid in the same cycle.
REQ-020 Otherwise the frame SHALL be discarded, with data_out and valid unchanged.
REQ-021 Latency: valid SHALL be high in the cycle after the (SYNC_STAGES+1)th clk edge that samples SS high.
REQ-022 An SCLK rise coincident with the SS rising edge SHALL NOT be shifted.
REQ-023 SCLK edges while SS is high SHALL be ignored.
REQ-024 data_out SHALL hold its value until the next valid; no overrun flag exists.
REQ-025 Input timing: SCLK high and low phases and the SS-high gap SHALL each be at least SYNC_STAGES+2 clk cycles; behaviour below this limit is undefined.

Reset
REQ-026 On reset the FSM SHALL enter ARM, with data_out=0, valid=0, busy=0, err=0, counter=0 and shift register=0.
REQ-027 Reset mid-frame (SS low) SHALL discard the partial frame; reception resumes only after SS is seen high and then falls again.
REQ-028 Synchronizer flops SHALL reset to SS=1, SCLK=0, MOSI=0.

Configuration
REQ-029 Macro SPI_RX_FRAME_CHECK_EN defined: on the SS rising edge with count!=BITS and count!=0, err SHALL pulse for one cycle.
REQ-030 Same macro: an SS falling edge seen while in ARM after reset SHALL also pulse err for one cycle.
REQ-031 Macro undefined: err SHALL be tied to 0, malformed frames are dropped silently, and no frame-check logic is synthesized.

Verification
REQ-032 BITS=32: send 12345 (0x00003039) in 32 SCLK cycles -> data_out=0x00003039, valid high for exactly 1 cycle at REQ-021 latency, busy low afterwards.
REQ-033 Back-to-back frames 0xFFFFFFFF then 0x80000001 with minimum gaps -> two valid pulses, data_out=0xFFFFFFFF then 0x80000001.
REQ-034 31-bit frame and 33-bit frame -> no valid, data_out unchanged; with SPI_RX_FRAME_CHECK_EN, err pulses once per frame; without it, err is constantly 0.
REQ-035 Reset asserted after 10 bits with SS held low, then 22 more SCLKs, then SS high -> no valid; the next 32-bit 0x12345678 frame gives data_out=0x12345678.
REQ-036 40 SCLK pulses with SS high, then a 0xA5A5A5A5 frame -> data_out=0xA5A5A5A5, and the counter was 0 at the SS falling edge.
REQ-037 SS released 1 cycle after the 32nd SCLK rise -> valid with correct data; an SCLK rise coincident with SS release is not counted.
